// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Op encodings match the 2-bit op field driven by the decode stage.
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_mul_op(input op_e op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
// The master side issues requests; the slave side is the unit itself.
interface muldiv_if #(
    parameter int XLEN = 32
);
    import muldiv_pkg::*;

    logic            start;
    op_e             op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            regwrite_out;

    modport master (
        output start, op, operand_a, operand_b, rd_in,
        input  busy, done, result, rd_out, regwrite_out
    );

    modport slave (
        input  start, op, operand_a, operand_b, rd_in,
        output busy, done, result, rd_out, regwrite_out
    );

endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 unsigned multiply/divide: 32 iterations on one 64-bit shift register
// and one 33-bit adder/subtractor; divide-by-zero short-circuits straight to DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(ITERATIONS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [2*XLEN-1:0] sr_q, sr_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              mul_mode;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     add_x;
    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] sr_step;

    assign mul_mode = is_mul_op(op_q);

    // Multiply: sr = {partial product hi, remaining multiplier bits}, shifted right.
    // Divide: sr = {partial remainder, dividend/quotient bits}, shifted left.
    always_comb begin
        rem_shift = sr_q[2*XLEN-1:XLEN-1];
        add_x     = mul_mode ? {1'b0, sr_q[2*XLEN-1:XLEN]} : rem_shift;
        add_sum   = mul_mode ? (add_x + {1'b0, opnd_q}) : (add_x - {1'b0, opnd_q});
        sr_step   = sr_q;
        if (mul_mode) begin
            if (sr_q[0]) begin
                sr_step = {add_sum, sr_q[XLEN-1:1]};
            end else begin
                sr_step = {1'b0, sr_q[2*XLEN-1:1]};
            end
        end else begin
            // Bit XLEN of the difference is the borrow: set means restore.
            if (!add_sum[XLEN]) begin
                sr_step = {add_sum[XLEN-1:0], sr_q[XLEN-2:0], 1'b1};
            end else begin
                sr_step = {rem_shift[XLEN-1:0], sr_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sr_d     = sr_q;
        opnd_d   = opnd_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d  = bus.op;
                    rd_d  = bus.rd_in;
                    cnt_d = '0;
                    if (is_mul_op(bus.op)) begin
                        sr_d    = {{XLEN{1'b0}}, bus.operand_b};
                        opnd_d  = bus.operand_a;
                        state_d = S_RUN;
                    end else if (bus.operand_b == '0) begin
                        result_d = (bus.op == OP_DIVU) ? '1 : bus.operand_a;
                        rd_out_d = bus.rd_in;
                        state_d  = S_DONE;
                    end else begin
                        sr_d    = {{XLEN{1'b0}}, bus.operand_a};
                        opnd_d  = bus.operand_b;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                sr_d  = sr_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // MULHU and REMU both live in the upper half; op bit 0 picks it.
                    result_d = op_q[0] ? sr_step[2*XLEN-1:XLEN] : sr_step[XLEN-1:0];
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            sr_q     <= '0;
            opnd_q   <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sr_q     <= sr_d;
            opnd_q   <= opnd_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.regwrite_out = (state_q == S_DONE);
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic scramble_inputs();
        bus.op        = op_e'($urandom_range(0, 3));
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.rd_in     = 5'($urandom);
    endtask

    // Issues one request and returns in the first IDLE cycle after done.
    task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input bit noisy,
                          output logic [31:0] got_res);
        int          lat_exp, cyc, ndone, lat;
        logic [31:0] exp, res;
        logic [4:0]  rdo;
        logic        rw, bz;
        exp     = model(op, a, b);
        lat_exp = ((op == OP_DIVU || op == OP_REMU) && b == 0) ? 1 : ITERATIONS + 1;
        res = '0; rdo = '0; rw = 1'b0; bz = 1'b0;
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.rd_in = rd;
        step();
        bus.start = 1'b0;
        scramble_inputs();
        ndone = 0; lat = -1; cyc = 1;
        while (ndone == 0 && cyc <= lat_exp + 5) begin
            if (bus.done) begin
                ndone = 1; lat = cyc;
                res = bus.result; rdo = bus.rd_out; rw = bus.regwrite_out; bz = bus.busy;
            end
            bus.start = noisy && (cyc == 5 || cyc == 20 || bus.done);
            scramble_inputs();
            if (ndone == 0) begin
                step();
                cyc++;
            end
        end
        check({tag, "_done_seen"}, 64'(ndone), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_result"}, 64'(res), 64'(exp));
        check({tag, "_rd_out"}, 64'(rdo), 64'(rd));
        check({tag, "_regwrite"}, 64'(rw), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bz), 64'd1);
        step();
        bus.start = 1'b0;
        check({tag, "_idle_after"}, 64'(bus.busy), 64'd0);
        check({tag, "_single_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_result_held"}, 64'(bus.result), 64'(exp));
        got_res = res;
    endtask

    task automatic idle_watch(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            if (bus.done || bus.busy) seen++;
            step();
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a, b;
        op_e         op;
        bus.start = 1'b0;
        scramble_inputs();
        repeat (3) step();
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_regwrite", 64'(bus.regwrite_out), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_rd_out", 64'(bus.rd_out), 64'd0);
        step();

        run_op("mul6x7", OP_MUL, 32'd6, 32'd7, 5'd9, 1'b0, r);
        check("mul6x7_const", 64'(r), 64'd42);
        run_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, r);
        check("mulhu_max_const", 64'(r), 64'hFFFF_FFFE);
        run_op("mul_zero", OP_MUL, 32'd0, 32'h1234_5678, 5'd4, 1'b0, r);
        run_op("divu100_7", OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b0, r);
        check("divu100_7_const", 64'(r), 64'd14);
        run_op("remu100_7", OP_REMU, 32'd100, 32'd7, 5'd6, 1'b0, r);
        check("remu100_7_const", 64'(r), 64'd2);
        run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd7, 1'b0, r);
        check("divu_max_1_const", 64'(r), 64'hFFFF_FFFF);
        run_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 5'd8, 1'b0, r);
        check("divu_by0_const", 64'(r), 64'hFFFF_FFFF);
        run_op("remu_by0", OP_REMU, 32'd5, 32'd0, 5'd10, 1'b0, r);
        check("remu_by0_const", 64'(r), 64'd5);
        idle_watch("gap_idle", 2);

        run_op("busy_rej", OP_MUL, 32'd3, 32'd4, 5'd11, 1'b1, r);
        check("busy_rej_const", 64'(r), 64'd12);
        idle_watch("busy_rej_no_queue", 6);
        check("busy_rej_hold", 64'(bus.result), 64'd12);

        bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        bus.rd_in = 5'd12;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_regwrite", 64'(bus.regwrite_out), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_rd_out", 64'(bus.rd_out), 64'd0);
        idle_watch("abort_no_pulse", 40);
        run_op("divu1000_3", OP_DIVU, 32'd1000, 32'd3, 5'd13, 1'b0, r);
        check("divu1000_3_const", 64'(r), 64'd333);

        run_op("b2b_first", OP_MUL, 32'd1000, 32'd1000, 5'd14, 1'b0, r);
        run_op("b2b_second", OP_DIVU, 32'd77, 32'd0, 5'd15, 1'b0, r);
        run_op("b2b_third", OP_REMU, 32'd77, 32'd10, 5'd16, 1'b0, r);
        idle_watch("b2b_idle", 2);

        for (int i = 0; i < 40; i++) begin
            op = op_e'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom), 1'b0, r);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clock and reset.
REQ-002 Parameter: XLEN, default 32, operand/result width; only 32 is supported.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 op  input  2  00 MUL (low product), 01 MULHU (high unsigned product), 10 DIVU, 11 REMU.
REQ-007 operand_a  input  XLEN  multiplicand/dividend, from register-file read_data1.
REQ-008 operand_b  input  XLEN  multiplier/divisor, from register-file read_data2.
REQ-009 rd_in  input  5  destination register number.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  XLEN  write_data to the register file.
REQ-013 rd_out  output  5  write_reg to the register file.
REQ-014 regwrite_out  output  1  equals done; drives register-file regwrite.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-016 IDLE->RUN on an edge with start=1. Latch op, operands and rd_in; clear the iteration counter.
REQ-017 Inputs SHALL be ignored outside the accepting edge.
REQ-018 RUN SHALL perform one radix-2 iteration per edge:
  - MUL/MULHU: shift-add over a 64-bit product.
  - DIVU/REMU: restoring shift-subtract (33-bit partial remainder, quotient shifted in).
REQ-019 RUN->DONE on the edge completing iteration 32.
REQ-020 Normal latency: start sampled at edge N; done=1 during the cycle after edge N+33.
REQ-021 DONE->IDLE on the next edge unconditionally.
REQ-022 done and regwrite_out SHALL be high only in DONE, for exactly one cycle.
REQ-023 result SHALL be:
  - MUL: product[31:0].
  - MULHU: product[63:32].
  - DIVU: quotient.
  - REMU: remainder.
REQ-024 result and rd_out SHALL hold their values from DONE until the next accepted start.
REQ-025 Divide by zero (DIVU/REMU with operand_b=0):
  - IDLE->DONE directly; done high in the cycle after edge N+1.
  - DIVU result = 0xFFFFFFFF.
  - REMU result = operand_a.
REQ-026 MUL/MULHU with a zero operand SHALL still take the full 32 iterations.
REQ-027 start during RUN or DONE, including the DONE cycle itself, SHALL be ignored and not queued.
REQ-028 All arithmetic SHALL be unsigned; no signed variants exist.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, busy=0, done=0, regwrite_out=0, result=0, rd_out=0, counter=0.
REQ-030 reset SHALL take priority over start and over any in-flight operation.
REQ-031 An operation aborted by reset SHALL produce no done pulse.
REQ-032 The first accepted start after reset deasserts SHALL behave as from power-up.

Structure
REQ-033 A shared package muldiv_pkg SHALL hold:
  - the op encodings;
  - the FSM state enum;
  - the constant ITERATIONS=32.
REQ-034 The block SHALL be a single module with no sub-module; multiply and divide share the 64-bit shift register and 33-bit adder/subtractor.

Verification
REQ-035 Multiply: MUL a=6, b=7 -> result=42, rd_out=rd_in, done exactly 33 cycles after start, single pulse. MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-036 Divide: DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2. DIVU a=0xFFFFFFFF, b=1 -> 0xFFFFFFFF.
REQ-037 Divide by zero: DIVU a=5, b=0 -> 0xFFFFFFFF. REMU a=5, b=0 -> 5. done 1 cycle after start in both cases.
REQ-038 Busy rejection: start with new operands on cycles 5, 20 and on the DONE cycle of a running MUL 3*4 -> only result 12 produced, one done pulse, FSM returns to IDLE.
REQ-039 Reset mid-operation: reset asserted at cycle 10 of DIVU 1000/3 -> done never pulses, all outputs 0. Subsequent DIVU 1000/3 -> 333 with normal latency.
REQ-040 Back-to-back: start asserted on the first IDLE cycle after a done -> accepted. Two consecutive results correct. Dead gap between done pulses is exactly one IDLE cycle.
